// File: rtl/stack_sequencer.sv
// Forth stack-word sequencer: expands one accepted op into 1-2 SmartStack strobes and guards depth.
// Optional ADD/SUB ops are compiled in when STACK_SEQ_ARITH_EN is defined.
module stack_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_done,
    output logic             o_fault,
    input  logic             i_clr_fault,
    output logic [DW-1:0]    o_depth,
    output logic             o_stk_strobe,
    output logic [2:0]       o_stk_func,
    output logic [WIDTH-1:0] o_stk_D,
    input  logic [WIDTH-1:0] i_stk_A,
    input  logic [WIDTH-1:0] i_stk_B
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PUSH = 4'd1;
    localparam logic [3:0] OP_DROP = 4'd2;
    localparam logic [3:0] OP_DUP  = 4'd3;
    localparam logic [3:0] OP_SWAP = 4'd4;
    localparam logic [3:0] OP_OVER = 4'd5;
    localparam logic [3:0] OP_NIP  = 4'd6;
    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_SUB  = 4'd9;

    localparam logic [2:0] FN_HOLD   = 3'd0;
    localparam logic [2:0] FN_PUSH   = 3'd1;
    localparam logic [2:0] FN_POP    = 3'd2;
    localparam logic [2:0] FN_REPL_A = 3'd3;
    localparam logic [2:0] FN_REPL_B = 3'd4;
    localparam logic [2:0] FN_POP_RA = 3'd5;

    localparam logic [DW-1:0] FULL_C = DW'(DEPTH);
    localparam logic [DW-1:0] ONE_C  = DW'(1);
    localparam logic [DW-1:0] TWO_C  = DW'(2);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_S1 = 2'd1, ST_S2 = 2'd2} state_t;

    state_t           state_r, state_s;
    logic [DW-1:0]    depth_r;
    logic             fault_r, swap_r, inc_r, dec_r, rej_r;
    logic [WIDTH-1:0] t0_r, t1_r;
    logic             strobe_r, done_r;
    logic [2:0]       func_r;
    logic [WIDTH-1:0] d_r;

    logic             accept_s, ok_s, cmd_strobe_s, swap_s, inc_s, dec_s;
    logic [2:0]       cmd_func_s;
    logic [WIDTH-1:0] cmd_d_s;
    logic             strobe_s, done_s;
    logic [2:0]       func_s;
    logic [WIDTH-1:0] d_s;

    // Depth precondition for each op; anything not listed is rejected.
    function automatic logic op_ok(input logic [3:0] op, input logic [DW-1:0] d);
        logic ok;
        case (op)
            OP_NOP:  ok = 1'b1;
            OP_PUSH: ok = (d < FULL_C);
            OP_DROP: ok = (d >= ONE_C);
            OP_DUP:  ok = (d >= ONE_C) && (d < FULL_C);
            OP_SWAP: ok = (d >= TWO_C);
            OP_OVER: ok = (d >= TWO_C) && (d < FULL_C);
            OP_NIP:  ok = (d >= TWO_C);
`ifdef STACK_SEQ_ARITH_EN
            OP_ADD:  ok = (d >= TWO_C);
            OP_SUB:  ok = (d >= TWO_C);
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign accept_s = i_valid && (state_r == ST_IDLE);

    // Decode the incoming op into its first stack command and depth effect.
    always_comb begin
        ok_s       = op_ok(i_op, depth_r);
        cmd_func_s = FN_HOLD;
        cmd_d_s    = {WIDTH{1'b0}};
        inc_s      = 1'b0;
        dec_s      = 1'b0;
        case (i_op)
            OP_PUSH: begin cmd_func_s = FN_PUSH;   cmd_d_s = i_data;  inc_s = 1'b1; end
            OP_DROP: begin cmd_func_s = FN_POP;                       dec_s = 1'b1; end
            OP_DUP:  begin cmd_func_s = FN_PUSH;   cmd_d_s = i_stk_A; inc_s = 1'b1; end
            OP_SWAP: begin cmd_func_s = FN_REPL_A; cmd_d_s = i_stk_B;               end
            OP_OVER: begin cmd_func_s = FN_PUSH;   cmd_d_s = i_stk_B; inc_s = 1'b1; end
            OP_NIP:  begin cmd_func_s = FN_POP_RA; cmd_d_s = i_stk_A; dec_s = 1'b1; end
`ifdef STACK_SEQ_ARITH_EN
            OP_ADD:  begin cmd_func_s = FN_POP_RA; cmd_d_s = i_stk_B + i_stk_A; dec_s = 1'b1; end
            OP_SUB:  begin cmd_func_s = FN_POP_RA; cmd_d_s = i_stk_B - i_stk_A; dec_s = 1'b1; end
`endif
            default: begin cmd_func_s = FN_HOLD; end
        endcase
        if (!ok_s) begin
            cmd_func_s = FN_HOLD;
            cmd_d_s    = {WIDTH{1'b0}};
            inc_s      = 1'b0;
            dec_s      = 1'b0;
        end else begin
            cmd_func_s = cmd_func_s;
        end
        cmd_strobe_s = ok_s && (cmd_func_s != FN_HOLD);
        swap_s       = ok_s && (i_op == OP_SWAP);
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_r <= ST_IDLE;
        else          state_r <= state_s;
    end

    // Next-state logic: only a legal SWAP needs the second step.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: if (accept_s) state_s = ST_S1; else state_s = ST_IDLE;
            ST_S1:   if (swap_r)   state_s = ST_S2; else state_s = ST_IDLE;
            ST_S2:   state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered stack command and done pulse.
    always_comb begin
        strobe_s = 1'b0;
        func_s   = FN_HOLD;
        d_s      = {WIDTH{1'b0}};
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    strobe_s = cmd_strobe_s;
                    func_s   = cmd_func_s;
                    d_s      = cmd_d_s;
                    done_s   = !swap_s;
                end else begin
                    done_s = 1'b0;
                end
            end
            ST_S1: begin
                if (swap_r) begin
                    strobe_s = 1'b1;
                    func_s   = FN_REPL_B;
                    d_s      = t0_r;
                    done_s   = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            default: done_s = 1'b0;
        endcase
    end

    // Registered stack command outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            strobe_r <= 1'b0;
            func_r   <= FN_HOLD;
            d_r      <= {WIDTH{1'b0}};
            done_r   <= 1'b0;
        end else begin
            strobe_r <= strobe_s;
            func_r   <= func_s;
            d_r      <= d_s;
            done_r   <= done_s;
        end
    end

    // Op context captured at accept; operand snapshots feed the SWAP second step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            swap_r <= 1'b0;
            inc_r  <= 1'b0;
            dec_r  <= 1'b0;
            rej_r  <= 1'b0;
            t0_r   <= {WIDTH{1'b0}};
            t1_r   <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            swap_r <= swap_s;
            inc_r  <= inc_s;
            dec_r  <= dec_s;
            rej_r  <= !ok_s;
            t0_r   <= i_stk_A;
            t1_r   <= i_stk_B;
        end else begin
            swap_r <= swap_r;
        end
    end

    // Depth and sticky fault commit at the end of the first step; a new reject beats a clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            depth_r <= {DW{1'b0}};
            fault_r <= 1'b0;
        end else begin
            if (state_r == ST_S1 && inc_r)      depth_r <= depth_r + ONE_C;
            else if (state_r == ST_S1 && dec_r) depth_r <= depth_r - ONE_C;
            else                                depth_r <= depth_r;
            if (state_r == ST_S1 && rej_r) fault_r <= 1'b1;
            else if (i_clr_fault)          fault_r <= 1'b0;
            else                           fault_r <= fault_r;
        end
    end

    assign o_ready      = (state_r == ST_IDLE);
    assign o_done       = done_r;
    assign o_fault      = fault_r;
    assign o_depth      = depth_r;
    assign o_stk_strobe = strobe_r;
    assign o_stk_func   = func_r;
    assign o_stk_D      = d_r;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed self-checking bench for stack_sequencer with a behavioural SmartStack model.
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        clr_fault = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [15:0] data = 16'd0;
    logic        ready, done, fault, strobe;
    logic [3:0]  depth;
    logic [2:0]  func;
    logic [15:0] stk_d, stk_a, stk_b;
    logic [15:0] mem [0:15];

    int errors = 0;
    int checks = 0;

    logic        c1_strobe, c1_done, c1_ready, c2_strobe, c2_done, c2_fault;
    logic [2:0]  c1_func, c2_func;
    logic [15:0] c1_d, c2_d;
    logic [3:0]  c2_depth;

    stack_sequencer #(.WIDTH(16), .DEPTH(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
        .i_op(op), .i_data(data), .o_done(done), .o_fault(fault),
        .i_clr_fault(clr_fault), .o_depth(depth), .o_stk_strobe(strobe),
        .o_stk_func(func), .o_stk_D(stk_d), .i_stk_A(stk_a), .i_stk_B(stk_b)
    );

    always #5 clk = ~clk;

    assign stk_a = mem[0];
    assign stk_b = mem[1];

    // SmartStack model, index 0 is top of stack
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'd0;
        end else if (strobe) begin
            case (func)
                3'd1: begin mem[0] <= stk_d; for (int i = 1; i < 16; i++) mem[i] <= mem[i-1]; end
                3'd2: begin for (int i = 0; i < 15; i++) mem[i] <= mem[i+1]; mem[15] <= 16'd0; end
                3'd3: mem[0] <= stk_d;
                3'd4: mem[1] <= stk_d;
                3'd5: begin mem[0] <= stk_d; for (int i = 1; i < 15; i++) mem[i] <= mem[i+1]; mem[15] <= 16'd0; end
                default: ;
            endcase
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        clr_fault = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_op(input logic [3:0] o, input logic [15:0] dv);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL ready_wait: got %0b want 1", ready); end
        valid = 1'b1; op = o; data = dv;
        @(posedge clk);
        #1 valid = 1'b0; op = 4'd0; data = 16'd0;
        @(negedge clk);
        c1_strobe = strobe; c1_func = func; c1_d = stk_d; c1_done = done; c1_ready = ready;
        @(negedge clk);
        c2_strobe = strobe; c2_func = func; c2_d = stk_d; c2_done = done;
        c2_depth = depth; c2_fault = fault;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (ready !== 1'b1)   begin errors++; $display("FAIL rst_ready: got %0b want 1", ready); end
        if (done !== 1'b0)    begin errors++; $display("FAIL rst_done: got %0b want 0", done); end
        if (fault !== 1'b0)   begin errors++; $display("FAIL rst_fault: got %0b want 0", fault); end
        if (depth !== 4'd0)   begin errors++; $display("FAIL rst_depth: got %0d want 0", depth); end
        if (strobe !== 1'b0)  begin errors++; $display("FAIL rst_strobe: got %0b want 0", strobe); end
        if (func !== 3'd0)    begin errors++; $display("FAIL rst_func: got %0d want 0", func); end
        if (stk_d !== 16'd0)  begin errors++; $display("FAIL rst_D: got %h want 0000", stk_d); end
    endtask

    task automatic test_underflow();
        send_op(4'd2, 16'd0);
        checks += 5;
        if (c1_strobe !== 1'b0) begin errors++; $display("FAIL uf_strobe: got %0b want 0", c1_strobe); end
        if (c1_done !== 1'b1)   begin errors++; $display("FAIL uf_done: got %0b want 1", c1_done); end
        if (c2_done !== 1'b0)   begin errors++; $display("FAIL uf_done_pulse: got %0b want 0", c2_done); end
        if (c2_fault !== 1'b1)  begin errors++; $display("FAIL uf_fault: got %0b want 1", c2_fault); end
        if (c2_depth !== 4'd0)  begin errors++; $display("FAIL uf_depth: got %0d want 0", c2_depth); end
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        checks++;
        if (fault !== 1'b0) begin errors++; $display("FAIL uf_clear: got %0b want 0", fault); end
    endtask

    task automatic test_swap();
        do_reset();
        send_op(4'd1, 16'h1111);
        checks += 5;
        if (c1_strobe !== 1'b1)  begin errors++; $display("FAIL push_strobe: got %0b want 1", c1_strobe); end
        if (c1_func !== 3'd1)    begin errors++; $display("FAIL push_func: got %0d want 1", c1_func); end
        if (c1_d !== 16'h1111)   begin errors++; $display("FAIL push_D: got %h want 1111", c1_d); end
        if (c1_done !== 1'b1)    begin errors++; $display("FAIL push_done: got %0b want 1", c1_done); end
        if (c1_ready !== 1'b0)   begin errors++; $display("FAIL push_busy: got %0b want 0", c1_ready); end
        send_op(4'd1, 16'h2222);
        send_op(4'd4, 16'd0);
        checks += 8;
        if (c1_func !== 3'd3 || c1_strobe !== 1'b1) begin errors++; $display("FAIL swap_s1_func: got %0d/%0b want 3/1", c1_func, c1_strobe); end
        if (c1_d !== 16'h1111)   begin errors++; $display("FAIL swap_s1_D: got %h want 1111", c1_d); end
        if (c1_done !== 1'b0)    begin errors++; $display("FAIL swap_s1_done: got %0b want 0", c1_done); end
        if (c2_func !== 3'd4 || c2_strobe !== 1'b1) begin errors++; $display("FAIL swap_s2_func: got %0d/%0b want 4/1", c2_func, c2_strobe); end
        if (c2_d !== 16'h2222)   begin errors++; $display("FAIL swap_s2_D: got %h want 2222", c2_d); end
        if (c2_done !== 1'b1)    begin errors++; $display("FAIL swap_s2_done: got %0b want 1", c2_done); end
        if (c2_depth !== 4'd2)   begin errors++; $display("FAIL swap_depth: got %0d want 2", c2_depth); end
        @(negedge clk);
        if (stk_a !== 16'h1111 || stk_b !== 16'h2222) begin errors++; $display("FAIL swap_AB: got %h/%h want 1111/2222", stk_a, stk_b); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) send_op(4'd1, 16'(i + 1));
        checks++;
        if (c2_depth !== 4'd8) begin errors++; $display("FAIL of_full: got %0d want 8", c2_depth); end
        send_op(4'd1, 16'hBEEF);
        checks += 4;
        if (c1_strobe !== 1'b0) begin errors++; $display("FAIL of_strobe: got %0b want 0", c1_strobe); end
        if (c1_done !== 1'b1)   begin errors++; $display("FAIL of_done: got %0b want 1", c1_done); end
        if (c2_depth !== 4'd8)  begin errors++; $display("FAIL of_depth: got %0d want 8", c2_depth); end
        if (c2_fault !== 1'b1)  begin errors++; $display("FAIL of_fault: got %0b want 1", c2_fault); end
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        checks++;
        if (fault !== 1'b0) begin errors++; $display("FAIL of_clear: got %0b want 0", fault); end
        clr_fault = 1'b1;
        send_op(4'd1, 16'hBEEF);
        clr_fault = 1'b0;
        checks++;
        if (c2_fault !== 1'b1) begin errors++; $display("FAIL of_set_wins: got %0b want 1", c2_fault); end
    endtask

    task automatic test_dup_over_nip();
        do_reset();
        send_op(4'd1, 16'h0005);
        checks++;
        if (c2_depth !== 4'd1) begin errors++; $display("FAIL push5_depth: got %0d want 1", c2_depth); end
        send_op(4'd3, 16'd0);
        checks += 2;
        if (c1_func !== 3'd1 || c1_d !== 16'h0005) begin errors++; $display("FAIL dup_cmd: got %0d/%h want 1/0005", c1_func, c1_d); end
        if (c2_depth !== 4'd2) begin errors++; $display("FAIL dup_depth: got %0d want 2", c2_depth); end
        send_op(4'd5, 16'd0);
        checks++;
        if (c2_depth !== 4'd3) begin errors++; $display("FAIL over_depth: got %0d want 3", c2_depth); end
        send_op(4'd6, 16'd0);
        checks += 3;
        if (c1_func !== 3'd5 || c1_d !== 16'h0005) begin errors++; $display("FAIL nip_cmd: got %0d/%h want 5/0005", c1_func, c1_d); end
        if (c2_depth !== 4'd2) begin errors++; $display("FAIL nip_depth: got %0d want 2", c2_depth); end
        if (stk_a !== 16'h0005 || stk_b !== 16'h0005) begin errors++; $display("FAIL nip_AB: got %h/%h want 0005/0005", stk_a, stk_b); end
    endtask

    task automatic test_arith();
        do_reset();
        send_op(4'd1, 16'hFFFF);
        send_op(4'd1, 16'h0002);
        send_op(4'd8, 16'd0);
        checks += 3;
`ifdef STACK_SEQ_ARITH_EN
        if (c1_strobe !== 1'b1 || c1_func !== 3'd5) begin errors++; $display("FAIL add_cmd: got %0b/%0d want 1/5", c1_strobe, c1_func); end
        if (c1_d !== 16'h0001) begin errors++; $display("FAIL add_D: got %h want 0001", c1_d); end
        if (c2_depth !== 4'd1) begin errors++; $display("FAIL add_depth: got %0d want 1", c2_depth); end
`else
        if (c1_strobe !== 1'b0) begin errors++; $display("FAIL add_strobe: got %0b want 0", c1_strobe); end
        if (c2_fault !== 1'b1)  begin errors++; $display("FAIL add_fault: got %0b want 1", c2_fault); end
        if (c2_depth !== 4'd2)  begin errors++; $display("FAIL add_depth: got %0d want 2", c2_depth); end
`endif
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        send_op(4'd15, 16'd0);
        checks++;
        if (c2_fault !== 1'b1) begin errors++; $display("FAIL undef_fault: got %0b want 1", c2_fault); end
        send_op(4'd1, 16'h0001);
        send_op(4'd1, 16'h0002);
        @(negedge clk);
        valid = 1'b1; op = 4'd4;
        @(posedge clk);
        #1 valid = 1'b0; op = 4'd0;
        @(negedge clk);
        checks++;
        if (strobe !== 1'b1) begin errors++; $display("FAIL mid_s1_strobe: got %0b want 1", strobe); end
        rst_n = 1'b0;
        #1;
        checks += 7;
        if (ready !== 1'b1)  begin errors++; $display("FAIL mid_ready: got %0b want 1", ready); end
        if (done !== 1'b0)   begin errors++; $display("FAIL mid_done: got %0b want 0", done); end
        if (fault !== 1'b0)  begin errors++; $display("FAIL mid_fault: got %0b want 0", fault); end
        if (depth !== 4'd0)  begin errors++; $display("FAIL mid_depth: got %0d want 0", depth); end
        if (strobe !== 1'b0) begin errors++; $display("FAIL mid_strobe: got %0b want 0", strobe); end
        if (func !== 3'd0)   begin errors++; $display("FAIL mid_func: got %0d want 0", func); end
        if (stk_d !== 16'd0) begin errors++; $display("FAIL mid_D: got %h want 0000", stk_d); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks += 2;
        if (ready !== 1'b1)  begin errors++; $display("FAIL mid_release_ready: got %0b want 1", ready); end
        if (strobe !== 1'b0) begin errors++; $display("FAIL mid_no_s2: got %0b want 0", strobe); end
    endtask

    initial begin
        test_reset();
        test_underflow();
        test_swap();
        test_overflow();
        test_dup_over_nip();
        test_arith();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
